// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_pkg;

  // Default widths for the fetch unit and its PC register.
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;

  // Top opcode byte that stops the sequencer.
  localparam logic [7:0] HALT_OP = 8'hFF;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  // True when an instruction's opcode byte is the halt opcode.
  function automatic logic is_halt_op(input logic [7:0] opcode);
    return opcode == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: async reset to RESET_PC, load has priority over increment.
module fetch_pc #(
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;

  // PC state: load beats increment; increment wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_val;
    end else if (inc) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: PC, memory req/ack handshake and IR write port.
// DATA_W must be at least 9 so the opcode byte sits above at least one operand bit.
module instr_fetch_unit
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_req,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_rdata,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_wr,
  output logic              fetch_done,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state_q;
  logic              im_req_q;
  logic [DATA_W-1:0] ir_data_q;
  logic              ir_wr_q;
  logic              fetch_done_q;
  logic              busy_q;
  logic              halted_q;
  // Jump target captured while a fetch is outstanding, applied in LOAD.
  logic              pend_q;
  logic [ADDR_W-1:0] pend_val_q;

  logic              pc_ld;
  logic [ADDR_W-1:0] pc_ld_val;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_cur;
  logic              load_is_halt;

  assign load_is_halt = is_halt_op(ir_data_q[DATA_W-1 -: 8]);

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      im_req_q     <= 1'b0;
      ir_data_q    <= '0;
      ir_wr_q      <= 1'b0;
      fetch_done_q <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_val_q   <= '0;
    end else begin
      ir_wr_q      <= 1'b0;
      fetch_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A jump in the same cycle as a fetch request wins; the request is dropped.
          if (!pc_load && fetch_req) begin
            state_q  <= WAIT;
            im_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        WAIT: begin
          if (pc_load) begin
            pend_q     <= 1'b1;
            pend_val_q <= pc_load_val;
          end
          if (im_ack) begin
            ir_data_q    <= im_rdata;
            im_req_q     <= 1'b0;
            ir_wr_q      <= 1'b1;
            fetch_done_q <= 1'b1;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          pend_q <= 1'b0;
          busy_q <= 1'b0;
          if (load_is_halt) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        HALT: begin
          if (pc_load) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // PC control: direct loads in IDLE/HALT, deferred redirect or increment in LOAD.
  always_comb begin
    pc_ld     = 1'b0;
    pc_ld_val = pc_load_val;
    pc_inc    = 1'b0;
    unique case (state_q)
      IDLE: pc_ld = pc_load;
      WAIT: pc_ld = 1'b0;
      LOAD: begin
        if (pend_q) begin
          pc_ld     = 1'b1;
          pc_ld_val = pend_val_q;
        end else begin
          pc_inc = !load_is_halt;
        end
      end
      HALT: pc_ld = pc_load;
    endcase
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_ld),
    .load_val (pc_ld_val),
    .inc      (pc_inc),
    .pc       (pc_cur)
  );

  assign im_addr    = pc_cur;
  assign pc         = pc_cur;
  assign im_req     = im_req_q;
  assign ir_data    = ir_data_q;
  assign ir_wr      = ir_wr_q;
  assign fetch_done = fetch_done_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a per-cycle phase model and literal checks.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic              pc_load = 1'b0;
  logic [ADDR_W-1:0] pc_load_val = '0;
  logic [ADDR_W-1:0] im_addr;
  logic              im_req;
  logic              im_ack = 1'b0;
  logic [DATA_W-1:0] im_rdata = '0;
  logic [DATA_W-1:0] ir_data;
  logic              ir_wr;
  logic              fetch_done;
  logic              busy;
  logic              halted;
  logic [ADDR_W-1:0] pc;

  int checks = 0;
  int failures = 0;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .im_addr     (im_addr),
    .im_req      (im_req),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .ir_data     (ir_data),
    .ir_wr       (ir_wr),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .halted      (halted),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 awaiting memory, 2 delivering word, 3 stopped.
  int          m_phase = 0;
  int          m_pc = 0;
  int          m_data = 0;
  bit          m_pend = 0;
  int          m_pend_val = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_pc    = 0;
      m_data  = 0;
      m_pend  = 0;
    end else begin
      case (m_phase)
        0: begin
          if (pc_load) m_pc = int'(pc_load_val);
          else if (fetch_req) m_phase = 1;
        end
        1: begin
          if (pc_load) begin
            m_pend     = 1;
            m_pend_val = int'(pc_load_val);
          end
          if (im_ack) begin
            m_data  = int'(im_rdata);
            m_phase = 2;
          end
        end
        2: begin
          if (m_pend) m_pc = m_pend_val;
          else if ((m_data >> 8) != 255) m_pc = (m_pc + 1) % 256;
          m_pend  = 0;
          m_phase = ((m_data >> 8) == 255) ? 3 : 0;
        end
        default: begin
          if (pc_load) begin
            m_pc    = int'(pc_load_val);
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    check("im_req",     32'(im_req),     32'(m_phase == 1));
    check("ir_wr",      32'(ir_wr),      32'(m_phase == 2));
    check("fetch_done", 32'(fetch_done), 32'(m_phase == 2));
    check("busy",       32'(busy),       32'(m_phase == 1 || m_phase == 2));
    check("halted",     32'(halted),     32'(m_phase == 3));
    check("pc",         32'(pc),         32'(m_pc));
    check("im_addr",    32'(im_addr),    32'(m_pc));
    check("ir_data",    32'(ir_data),    32'(m_data));
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [ADDR_W-1:0] v);
    pc_load = 1'b1;
    pc_load_val = v;
    cyc();
    pc_load = 1'b0;
  endtask

  // Ack the outstanding request after 'waits' idle cycles, then step through LOAD.
  task automatic ack_after(input int waits, input logic [DATA_W-1:0] d);
    repeat (waits) begin
      check("req_held", 32'(im_req), 32'd1);
      cyc();
    end
    im_ack = 1'b1;
    im_rdata = d;
    cyc();
    im_ack = 1'b0;
    check("load_wr", 32'(ir_wr), 32'd1);
    check("load_data", 32'(ir_data), 32'(d));
    cyc();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_req", 32'(im_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Single fetch, two wait cycles.
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("t1_addr", 32'(im_addr), 32'h00);
    ack_after(2, 16'h1234);
    check("t1_pc", 32'(pc), 32'h01);
    check("t1_wr_off", 32'(ir_wr), 32'd0);

    // Wrap from 0xFF.
    load_pc(8'hFF);
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("wrap_addr", 32'(im_addr), 32'hFF);
    ack_after(0, 16'h0102);
    check("wrap_pc", 32'(pc), 32'h00);

    // Redirect while waiting.
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    load_pc(8'h40);
    check("redir_addr", 32'(im_addr), 32'h00);
    ack_after(1, 16'h0001);
    check("redir_pc", 32'(pc), 32'h40);

    // Halt opcode.
    load_pc(8'h05);
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    ack_after(0, 16'hFF07);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc), 32'h05);
    fetch_req = 1'b1;
    cyc();
    cyc();
    fetch_req = 1'b0;
    check("halt_noreq", 32'(im_req), 32'd0);
    check("halt_hold", 32'(halted), 32'd1);
    load_pc(8'h10);
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_pc", 32'(pc), 32'h10);

    // Jump and fetch request in the same idle cycle.
    fetch_req = 1'b1;
    load_pc(8'h22);
    fetch_req = 1'b0;
    check("coll_pc", 32'(pc), 32'h22);
    check("coll_req", 32'(im_req), 32'd0);
    check("coll_busy", 32'(busy), 32'd0);

    // Spurious ack in idle.
    im_ack = 1'b1;
    im_rdata = 16'hBEEF;
    cyc();
    im_ack = 1'b0;
    check("spur_wr", 32'(ir_wr), 32'd0);
    cyc();
    check("spur_pc", 32'(pc), 32'h22);
    check("spur_data", 32'(ir_data), 32'hFF07);

    // Asynchronous reset while waiting.
    fetch_req = 1'b1;
    cyc();
    fetch_req = 1'b0;
    check("arst_pre", 32'(im_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(im_req), 32'd0);
    check("arst_pc", 32'(pc), 32'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    im_ack = 1'b1;
    im_rdata = 16'h5555;
    cyc();
    im_ack = 1'b0;
    check("arst_nowr", 32'(ir_wr), 32'd0);
    cyc();
    check("arst_data", 32'(ir_data), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
